// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline constants and the fetch FSM state encoding.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush bubbles, load captures, stall holds, otherwise bubbles.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_stall,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_pc    <= '0;
            o_instr <= NOP_INSTR;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            o_instr <= NOP_INSTR;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_pc    <= i_pc;
            o_instr <= i_instr;
        end else if (!i_stall) begin
            // previous instruction advanced and nothing new arrived
            o_valid <= 1'b0;
            o_instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, one-outstanding imem handshake, skid buffer and IF/ID register.
// Optional FETCH_PERF_EN adds saturating stall/flush cycle counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_flush_count
`endif
);

    fetch_state_t    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic            r_squash, w_squash_nxt;
    logic [31:0]     r_buf, w_buf_nxt;
    logic            w_load;
    logic [31:0]     w_load_instr;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_inc;
    logic            w_unused_tgt;

    assign w_target     = {branch_target[XLEN-1:2], 2'b00};
    assign w_pc_inc     = r_pc + XLEN'(4);
    assign w_unused_tgt = ^branch_target[1:0];

    // Request is held off during reset so the first pulse lands after release.
    assign imem_req  = rst_n && (r_state == FETCH) && !flush;
    assign imem_addr = r_pc;

    // Next-state, PC, squash and skid-buffer decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_squash_nxt = r_squash;
        w_buf_nxt    = r_buf;
        w_load       = 1'b0;
        w_load_instr = imem_rdata;
        case (r_state)
            FETCH: begin
                if (!flush) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (r_squash || flush) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = FETCH;
                    end else if (!stall) begin
                        w_load      = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = FETCH;
                    end else begin
                        w_buf_nxt   = imem_rdata;
                        w_state_nxt = HOLD;
                    end
                end else if (flush) begin
                    w_squash_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    w_state_nxt = FETCH;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_instr = r_buf;
                    w_pc_nxt     = w_pc_inc;
                    w_state_nxt  = FETCH;
                end
            end
            default: w_state_nxt = FETCH;
        endcase
        if (flush) w_pc_nxt = w_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_squash <= 1'b0;
            r_buf    <= NOP_INSTR;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_squash <= w_squash_nxt;
            r_buf    <= w_buf_nxt;
        end
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_stall (stall),
        .i_load  (w_load),
        .i_pc    (r_pc),
        .i_instr (w_load_instr),
        .o_valid (if_id_valid),
        .o_pc    (if_id_pc),
        .o_instr (if_id_instr)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (stall && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush && (perf_flush_count != '1))  perf_flush_count  <= perf_flush_count + 32'd1;
        end
    end
`endif

    // A response is only legal while a request is outstanding.
    rvalid_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (r_state == WAIT))
        else $error("imem_rvalid outside WAIT");

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: 1-cycle memory model, stall, flush, reset and perf cases.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    logic        auto_mem = 1'b1;
    logic        gap_chk = 1'b0;
    int          cyc = 0;
    int          last_req = -1;
    logic [31:0] exp_addr = '0;
    logic [31:0] last_pc = '0;
    logic        saw_req = 1'b0;
    logic [31:0] saw_addr = '0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .flush             (flush),
        .branch_target     (branch_target),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_instr       (if_id_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], 16'h0093} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample request before the edge, then model memory and scoreboard after it.
    task automatic cycle();
        logic        req, s, f;
        logic [31:0] addr;
        logic [63:0] item;
        #3;
        req = imem_req;
        addr = imem_addr;
        s = stall;
        f = flush;
        saw_req = req;
        saw_addr = addr;
        if (req) begin
            check("imem_addr", 64'(addr), 64'(exp_addr));
            if (gap_chk && last_req >= 0) check("req_gap", 64'(cyc - last_req), 64'd2);
            last_req = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        if (!rst_n) return;
        if (f) begin
            sb.delete();
            exp_addr = {branch_target[31:2], 2'b00};
            check("flush_valid", 64'(if_id_valid), 64'd0);
            check("flush_instr", 64'(if_id_instr), 64'(NOP_INSTR));
        end else if (!s) begin
            if (if_id_valid) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", 64'(if_id_valid), 64'd0);
                end else begin
                    item = sb.pop_front();
                    check("if_id_pc", 64'(if_id_pc), 64'(item[63:32]));
                    check("if_id_instr", 64'(if_id_instr), 64'(item[31:0]));
                    last_pc = item[63:32];
                    exp_addr = item[63:32] + 32'd4;
                end
            end else begin
                check("bubble_instr", 64'(if_id_instr), 64'(NOP_INSTR));
            end
        end
        if (auto_mem && req) begin
            imem_rvalid = 1'b1;
            imem_rdata = instr_of(addr);
            sb.push_back({addr, instr_of(addr)});
        end
    endtask

    task automatic run_until_valid(input string tag);
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (if_id_valid) break;
        end
        check(tag, 64'(if_id_valid), 64'd1);
    endtask

    initial begin
        // Reset values
        @(posedge clk);
        #1;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(if_id_valid), 64'd0);
        check("rst_pc", 64'(if_id_pc), 64'd0);
        check("rst_instr", 64'(if_id_instr), 64'(NOP_INSTR));
        rst_n = 1'b1;

        // 1: free-running fetch with 1-cycle memory
        gap_chk = 1'b1;
        repeat (8) cycle();
        gap_chk = 1'b0;

        // 2: stall arriving with the response, held for three cycles
        for (int k = 0; k < 10; k++) begin
            if (imem_rvalid) break;
            cycle();
        end
        check("t2_rvalid_seen", 64'(imem_rvalid), 64'd1);
        stall = 1'b1;
        repeat (3) begin
            cycle();
            check("t2_hold_valid", 64'(if_id_valid), 64'd0);
            check("t2_hold_instr", 64'(if_id_instr), 64'(NOP_INSTR));
        end
        stall = 1'b0;
        cycle();
        check("t2_release_valid", 64'(if_id_valid), 64'd1);
        repeat (3) cycle();

        // 3: flush while WAIT, late response must be squashed
        auto_mem = 1'b0;
        cycle();
        for (int k = 0; k < 8; k++) begin
            if (saw_req) break;
            cycle();
        end
        check("t3_req_issued", 64'(saw_req), 64'd1);
        flush = 1'b1;
        branch_target = 32'h0000_0103;
        cycle();
        flush = 1'b0;
        cycle();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cycle();
        check("t3_squash_valid", 64'(if_id_valid), 64'd0);
        auto_mem = 1'b1;
        cycle();
        check("t3_redirect_req", 64'(saw_req), 64'd1);
        check("t3_redirect_addr", 64'(saw_addr), 64'h100);
        run_until_valid("t3_resume_valid");

        // 4: stall and flush together, flush wins
        stall = 1'b1;
        flush = 1'b1;
        branch_target = 32'h0000_0200;
        cycle();
        stall = 1'b0;
        flush = 1'b0;
        check("t4_no_req", 64'(saw_req), 64'd0);
        cycle();
        check("t4_redirect_addr", 64'(saw_addr), 64'h200);
        run_until_valid("t4_resume_valid");
        check("t4_resume_pc", 64'(if_id_pc), 64'h200);

        // 5: reset asserted mid-WAIT with IF/ID held
        stall = 1'b1;
        cycle();
        check("t5_hold_valid", 64'(if_id_valid), 64'd1);
        check("t5_hold_pc", 64'(if_id_pc), 64'(last_pc));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_req", 64'(imem_req), 64'd0);
        check("t5_rst_valid", 64'(if_id_valid), 64'd0);
        check("t5_rst_pc", 64'(if_id_pc), 64'd0);
        check("t5_rst_instr", 64'(if_id_instr), 64'(NOP_INSTR));
        stall = 1'b0;
        sb.delete();
        exp_addr = '0;
        cycle();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("t5_first_req", 64'(saw_req), 64'd1);
        check("t5_first_addr", 64'(saw_addr), 64'h0);
        run_until_valid("t5_resume_valid");
        check("t5_resume_pc", 64'(if_id_pc), 64'h0);

`ifdef FETCH_PERF_EN
        // 6: performance counters
        rst_n = 1'b0;
        sb.delete();
        exp_addr = '0;
        cycle();
        rst_n = 1'b1;
        stall = 1'b1;
        repeat (5) cycle();
        stall = 1'b0;
        repeat (2) cycle();
        flush = 1'b1;
        branch_target = 32'h0000_0300;
        cycle();
        flush = 1'b0;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        check("t6_stall_cycles", 64'(perf_stall_cycles), 64'd5);
        check("t6_flush_count", 64'(perf_flush_count), 64'd2);
`endif

        repeat (4) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
